pipeline_hazard_controller: RTL

Sequences the front end of the pipelined ARM core: decides each cycle whether the PC advances, whether the instruction-fetch pipeline register loads, holds, or captures a no-op, and whether a bubble enters decode. Resolves three hazards: taken-branch flush, data-memory wait, and load-use. Sits beside the fetch/decode registers and drives their enable and noop inputs. Keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/pipeline_hazard_controller_sat_counter.sv | 28 ++
 rtl/pipeline_hazard_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the front-end hazard controller.
//   hz_state_t : controller FSM state (RUN / FLUSH / MEM_WAIT; encoding 3 is illegal)
//   REG_PC     : architectural PC register number; never a load-use source
//   COUNT_W    : width of the performance-debug event counters
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [3:0] REG_PC  = 4'd15;
  localparam int         COUNT_W = 16;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter used for stall/flush event counting.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears count
//   en    : count this cycle
//   clr   : synchronous clear (wins over en)
//   count : current value; sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Front-end sequencer for the pipelined core. Each cycle decides PC advance,
// fetch-register load/hold/noop, decode bubble and back-end freeze, resolving
// memory wait, taken-branch flush and load-use hazards (in that priority).
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   decRn/decRm/decRd, decUses*   : decode-stage source registers and qualifiers
//   exValid, exMemRead, exRd      : execute-stage load information
//   branchTaken                   : execute resolved a taken branch
//   memReq, memReady              : data-memory handshake
//   pcWriteEnable, fetchRegEnable : PC / fetch register load enables
//   fetchNoop, decodeNoop         : bubble injection into fetch / decode registers
//   pipeFreeze                    : holds execute, memory, writeback registers
//   stallCount, flushCount        : saturating event counters
//   state                         : FSM state for debug
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         decRn,
  input  logic [3:0]         decRm,
  input  logic [3:0]         decRd,
  input  logic               decUsesRn,
  input  logic               decUsesRm,
  input  logic               decUsesRd,
  input  logic               exValid,
  input  logic               exMemRead,
  input  logic [3:0]         exRd,
  input  logic               branchTaken,
  input  logic               memReq,
  input  logic               memReady,
  output logic               pcWriteEnable,
  output logic               fetchRegEnable,
  output logic               fetchNoop,
  output logic               decodeNoop,
  output logic               pipeFreeze,
  output logic [COUNT_W-1:0] stallCount,
  output logic [COUNT_W-1:0] flushCount,
  output logic [1:0]         state
);

  // flushCnt value loaded on a taken branch: the branch cycle itself is the
  // first noop cycle, FLUSH then runs until the counter reaches zero.
  localparam logic [2:0] FLUSH_RELOAD = 3'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
  localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);

  hz_state_t  state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       mem_wait;
  logic       load_use;

  // Once in MEM_WAIT the freeze holds until memReady, regardless of memReq.
  assign mem_wait = ~memReady & (memReq | (state_q == MEM_WAIT));

  assign load_use = exValid & exMemRead & (exRd != REG_PC) &
                    ((decUsesRn & (decRn == exRd)) |
                     (decUsesRm & (decRm == exRd)) |
                     (decUsesRd & (decRd == exRd)));

  always_comb begin
    pcWriteEnable  = 1'b1;
    fetchRegEnable = 1'b1;
    fetchNoop      = 1'b0;
    decodeNoop     = 1'b0;
    pipeFreeze     = 1'b0;
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;

    if (reset) begin
      pcWriteEnable = 1'b0;
      fetchNoop     = 1'b1;
      decodeNoop    = 1'b1;
      state_d       = RUN;
      flush_cnt_d   = 3'd0;
    end else if (mem_wait) begin
      // Any pending flush is dropped; the held branch re-resolves on release.
      pcWriteEnable  = 1'b0;
      fetchRegEnable = 1'b0;
      pipeFreeze     = 1'b1;
      state_d        = MEM_WAIT;
      flush_cnt_d    = 3'd0;
    end else begin
      unique case (state_q)
        RUN, MEM_WAIT: begin
          // MEM_WAIT with memReady behaves as RUN in the release cycle.
          state_d = RUN;
          if (branchTaken) begin
            fetchNoop  = 1'b1;
            decodeNoop = 1'b1;
            if (FLUSH_MULTI) begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_RELOAD;
            end
          end else if (load_use) begin
            pcWriteEnable  = 1'b0;
            fetchRegEnable = 1'b0;
            decodeNoop     = 1'b1;
          end
        end
        FLUSH: begin
          fetchNoop = 1'b1;
          if (branchTaken) begin
            decodeNoop = 1'b1;
            if (FLUSH_MULTI) begin
              flush_cnt_d = FLUSH_RELOAD;
            end else begin
              state_d = RUN;
            end
          end else if (flush_cnt_q == 3'd0) begin
            state_d = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        default: begin
          state_d     = RUN;
          flush_cnt_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state = state_q;

  sat_counter #(.W(COUNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (~pcWriteEnable),
    .clr   (1'b0),
    .count (stallCount)
  );

  sat_counter #(.W(COUNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (fetchNoop),
    .clr   (1'b0),
    .count (flushCount)
  );

endmodule
